wrr_arbiter: RTL and testbench

Parametrised N-to-1 valid/ready arbiter with a registered output stage. It is the next generation of the fixed 4-master round-robin arbiter, generalised to any master count. It adds per-master weighted round-robin (burst credit), a runtime fixed-priority mode and a granted-source ID on the output. It sits between multiple request producers (DMA/engine ports) and a single downstream consumer.

---
 rtl/wrr_arbiter.sv | 110 +++++++++++
 tb/tb_wrr_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: N-to-1 valid/ready arbiter with a registered output stage.
// Each master gets a burst of eff_weight grants in a row while it keeps
// requesting (weighted round-robin); mode_i=1 switches to fixed priority,
// where the lowest index wins.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mode_i              0 = weighted round-robin, 1 = fixed priority
//   cfg_weight_i[N]     per-master burst weight (0 behaves as 1)
//   src_valid_i[N]      source request
//   src_ready_o[N]      one-hot accept, combinational
//   src_data_i[N]       source payload
//   dst_valid_o         output register holds data
//   dst_ready_i         downstream accept
//   dst_data_o          registered payload
//   dst_id_o            index of the source behind dst_data_o
module wrr_arbiter #(
    parameter  int N_MASTER  = 4,
    parameter  int DATA_SIZE = 32,
    parameter  int WEIGHT_W  = 4,
    localparam int ID_W      = $clog2(N_MASTER)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                mode_i,
    input  logic [N_MASTER-1:0][WEIGHT_W-1:0]   cfg_weight_i,
    input  logic [N_MASTER-1:0]                 src_valid_i,
    output logic [N_MASTER-1:0]                 src_ready_o,
    input  logic [N_MASTER-1:0][DATA_SIZE-1:0]  src_data_i,
    output logic                                dst_valid_o,
    input  logic                                dst_ready_i,
    output logic [DATA_SIZE-1:0]                dst_data_o,
    output logic [ID_W-1:0]                     dst_id_o
);

    logic [ID_W-1:0]                    ptr;     // last winner
    logic [WEIGHT_W-1:0]                credit;  // grants left for ptr's burst
    logic [ID_W-1:0]                    win;
    logic [ID_W:0]                      cand;    // one extra bit: ptr+k reaches 2N-1
    logic [N_MASTER-1:0][WEIGHT_W-1:0]  eff_w;
    logic                               load, any_valid, hold, grant, found;

    for (genvar g = 0; g < N_MASTER; g++) begin : g_eff_w
        assign eff_w[g] = (cfg_weight_i[g] == '0) ? WEIGHT_W'(1) : cfg_weight_i[g];
    end

    assign load      = !dst_valid_o || dst_ready_i;
    assign any_valid = |src_valid_i;
    // Burst continues only while the holder keeps requesting; otherwise its
    // leftover credit is dropped by the normal search below.
    assign hold      = !mode_i && (credit != '0) && src_valid_i[ptr];
    // Gate with rst_n so no source sees an accept while the block is held in reset.
    assign grant     = rst_n && load && any_valid;

    always_comb begin
        win   = ptr;
        found = 1'b0;
        cand  = '0;
        if (mode_i) begin
            for (int i = 0; i < N_MASTER; i++) begin
                if (!found && src_valid_i[i]) begin
                    win   = ID_W'(i);
                    found = 1'b1;
                end
            end
        end else if (!hold) begin
            // Search ptr+1 .. ptr+N; the last candidate is ptr itself so a
            // lone requester keeps winning. Wrap at N_MASTER, not 2^ID_W.
            for (int k = 1; k <= N_MASTER; k++) begin
                cand = {1'b0, ptr} + (ID_W+1)'(k);
                if (cand >= (ID_W+1)'(N_MASTER))
                    cand = cand - (ID_W+1)'(N_MASTER);
                if (!found && src_valid_i[cand[ID_W-1:0]]) begin
                    win   = cand[ID_W-1:0];
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        src_ready_o = '0;
        if (grant)
            src_ready_o[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_valid_o <= 1'b0;
            dst_data_o  <= '0;
            dst_id_o    <= '0;
            ptr         <= ID_W'(N_MASTER-1);  // master 0 is first in line
            credit      <= '0;
        end else if (load) begin
            dst_valid_o <= any_valid;
            if (any_valid) begin
                dst_data_o <= src_data_i[win];
                dst_id_o   <= win;
                ptr        <= win;
                if (mode_i)
                    credit <= '0;
                else if (hold)
                    credit <= credit - WEIGHT_W'(1);
                else
                    credit <= eff_w[win] - WEIGHT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: a 4-master instance (a_*) and a 3-master
// instance (b_*). Stimulus pushes the expected {id, data} of each grant into
// a per-instance queue; a negedge monitor pops and compares on every output
// transfer.
module tb_wrr_arbiter;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 16'd1;

    logic             rst_a, mode_a, rdy_a, dv_a;
    logic [3:0]       va, ra;
    logic [3:0][3:0]  wa;
    logic [3:0][31:0] da;
    logic [31:0]      dd_a;
    logic [1:0]       id_a;

    logic             rst_b, mode_b, rdy_b, dv_b;
    logic [2:0]       vb, rb;
    logic [2:0][3:0]  wb;
    logic [2:0][31:0] db;
    logic [31:0]      dd_b;
    logic [1:0]       id_b;

    exp_t        qa[$], qb[$];
    logic [31:0] last_data;
    int          tests = 0;
    int          fails = 0;

    // Payload tags the cycle and the source so stale or wrong-source data shows up.
    always_comb begin
        for (int i = 0; i < 4; i++) da[i] = {cyc, 16'(i)};
        for (int i = 0; i < 3; i++) db[i] = {cyc, 16'(i + 8)};
    end

    wrr_arbiter #(.N_MASTER(4), .DATA_SIZE(32), .WEIGHT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_a), .mode_i(mode_a), .cfg_weight_i(wa),
        .src_valid_i(va), .src_ready_o(ra), .src_data_i(da),
        .dst_valid_o(dv_a), .dst_ready_i(rdy_a), .dst_data_o(dd_a), .dst_id_o(id_a)
    );

    wrr_arbiter #(.N_MASTER(3), .DATA_SIZE(32), .WEIGHT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_b), .mode_i(mode_b), .cfg_weight_i(wb),
        .src_valid_i(vb), .src_ready_o(rb), .src_data_i(db),
        .dst_valid_o(dv_b), .dst_ready_i(rdy_b), .dst_data_o(dd_b), .dst_id_o(id_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus: drive inputs after the edge, check src_ready_o
    // against the hand-computed winner, queue the expected output.
    task automatic step(input bit b, input logic [3:0] mask, input logic md,
                        input logic rd, input int exp_id, input bit g);
        logic [3:0] er;
        exp_t       e;
        @(posedge clk); #1;
        if (b) begin vb = mask[2:0]; mode_b = md; rdy_b = rd; end
        else   begin va = mask;      mode_a = md; rdy_a = rd; end
        #1;
        er = g ? 4'(1 << exp_id) : 4'h0;
        if (b) chk("b_src_ready", 32'(rb), 32'(er));
        else   chk("a_src_ready", 32'(ra), 32'(er));
        if (g) begin
            e.id   = exp_id;
            e.data = {cyc, 16'(b ? exp_id + 8 : exp_id)};
            last_data = e.data;
            if (b) qb.push_back(e); else qa.push_back(e);
        end
    endtask

    task automatic reset_a();
        @(posedge clk); #1;
        va = '0; rst_a = 1'b0;
        #1 chk("a_async_rst_valid", 32'(dv_a), 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b1;
        qa.delete();   // whatever was in flight is lost by design
    endtask

    always @(negedge clk) begin
        if (rst_a && dv_a && rdy_a) begin
            if (qa.size() == 0) begin
                tests++; fails++;
                $display("FAIL a_unexpected_out: got id %0d expected none", id_a);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_dst_id", 32'(id_a), 32'(e.id));
                chk("a_dst_data", dd_a, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_b && dv_b && rdy_b) begin
            if (qb.size() == 0) begin
                tests++; fails++;
                $display("FAIL b_unexpected_out: got id %0d expected none", id_b);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_dst_id", 32'(id_b), 32'(e.id));
                chk("b_dst_data", dd_b, e.data);
            end
        end
    end

    int s_rr[6]  = '{0, 1, 2, 3, 0, 1};
    int s_wt[9]  = '{0, 0, 1, 2, 3, 3, 3, 0, 0};
    int s_b1[4]  = '{0, 1, 2, 0};
    int s_b2[5]  = '{0, 1, 2, 0, 1};

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        va = '0; vb = '0; mode_a = 1'b0; mode_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1;
        wa = {4{4'h1}}; wb = {3{4'h1}};

        // Reset state, and no accepts while held in reset.
        #2;
        chk("a_rst_valid", 32'(dv_a), 32'd0);
        chk("a_rst_data", dd_a, 32'd0);
        chk("a_rst_id", 32'(id_a), 32'd0);
        chk("b_rst_valid", 32'(dv_b), 32'd0);
        va = 4'hf;
        #1 chk("a_rst_ready", 32'(ra), 32'd0);
        va = '0;
        @(posedge clk); #1;
        rst_a = 1'b1; rst_b = 1'b1;

        // Plain round-robin, all weights 1.
        foreach (s_rr[i]) step(0, 4'hf, 0, 1, s_rr[i], 1);
        step(0, 4'hf, 0, 1, 2, 1);

        // Backpressure: output holds id 2, no accepts for 5 cycles.
        repeat (5) begin
            step(0, 4'hf, 0, 0, 0, 0);
            chk("a_hold_valid", 32'(dv_a), 32'd1);
            chk("a_hold_id", 32'(id_a), 32'd2);
            chk("a_hold_data", dd_a, last_data);
        end
        step(0, 4'hf, 0, 1, 3, 1);
        step(0, 4'hf, 0, 1, 0, 1);

        // Weights {2,1,1,3}.
        wa = {4'd3, 4'd1, 4'd1, 4'd2};
        reset_a();
        foreach (s_wt[i]) step(0, 4'hf, 0, 1, s_wt[i], 1);

        // Fixed priority, then back to RR searching after the last winner.
        wa = {4{4'h1}};
        reset_a();
        step(0, 4'b1010, 1, 1, 1, 1);
        step(0, 4'b1010, 1, 1, 1, 1);
        step(0, 4'b1000, 1, 1, 3, 1);
        step(0, 4'b1010, 1, 1, 1, 1);
        step(0, 4'b1010, 0, 1, 3, 1);
        step(0, 4'b1010, 0, 1, 1, 1);
        step(0, 4'b1010, 0, 1, 3, 1);

        // Holder drops mid-burst; on return it gets a fresh credit of 3.
        wa = {4'd1, 4'd1, 4'd1, 4'd3};
        reset_a();
        step(0, 4'b0101, 0, 1, 0, 1);
        step(0, 4'b0100, 0, 1, 2, 1);
        step(0, 4'b0101, 0, 1, 0, 1);
        step(0, 4'b0101, 0, 1, 0, 1);
        step(0, 4'b0101, 0, 1, 0, 1);
        step(0, 4'b0101, 0, 1, 2, 1);

        // Zero weights behave as 1.
        wa = '0;
        reset_a();
        foreach (s_rr[i]) step(0, 4'hf, 0, 1, s_rr[i], 1);

        // Idle: no requests -> output goes invalid.
        step(0, 4'h0, 0, 1, 0, 0);
        step(0, 4'h0, 0, 1, 0, 0);
        chk("a_idle_valid", 32'(dv_a), 32'd0);

        // Three masters: wrap at 2 -> 0, async reset pulse mid-stream.
        foreach (s_b1[i]) step(1, 4'h7, 0, 1, s_b1[i], 1);
        #1 chk("b_valid_before_rst", 32'(dv_b), 32'd1);
        rst_b = 1'b0;
        #1 chk("b_async_rst_valid", 32'(dv_b), 32'd0);
        chk("b_rst_ready", 32'(rb), 32'd0);
        vb = '0;
        @(posedge clk); #1;
        rst_b = 1'b1;
        qb.delete();
        foreach (s_b2[i]) step(1, 4'h7, 0, 1, s_b2[i], 1);
        step(1, 4'h0, 0, 1, 0, 0);
        step(1, 4'h0, 0, 1, 0, 0);

        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
